// File: rtl/mem_arbiter_v1.sv
// mem_arbiter_v1: two-port req/gnt arbiter that sequences one access at a time onto memory_v2.
// Optional MEM_ARB_ROUND_ROBIN_EN: round-robin on contention; otherwise port 1 has fixed priority.
module mem_arbiter_v1 #(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [addr_width-1:0] p0_addr,
  input  logic [data_width-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_done,
  output logic [data_width-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [addr_width-1:0] p1_addr,
  input  logic [data_width-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_done,
  output logic [data_width-1:0] p1_rdata,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_data_in,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [data_width-1:0] mem_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    grant_s;
  logic                    win_s;
  logic                    win_r;
  logic                    we_r;
  logic                    sel_we_s;
  logic [addr_width-1:0]   sel_addr_s;
  logic [data_width-1:0]   sel_wdata_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // High when port 0 took the most recent grant; reset value lets port 0 win first.
  logic                    rr_ptr_r;
`endif

  assign sel_we_s    = win_s ? p1_we    : p0_we;
  assign sel_addr_s  = win_s ? p1_addr  : p0_addr;
  assign sel_wdata_s = win_s ? p1_wdata : p0_wdata;

  // Grants are combinational in IDLE and forced low while reset is asserted.
  assign p0_gnt = rst & grant_s & ~win_s;
  assign p1_gnt = rst & grant_s & win_s;
  // A grant in the done cycle keeps busy high across back-to-back accesses.
  assign busy   = (state_r != IDLE) | (rst & grant_s);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and arbitration
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    win_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant_s = 1'b1;
          state_s = ISSUE;
          if (p0_req && p1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_s = rr_ptr_r;
`else
            win_s = 1'b1;
`endif
          end else begin
            win_s = p1_req;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last-winner pointer, advanced on every grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= 1'b0;
    end else if (grant_s) begin
      rr_ptr_r <= ~win_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // Command capture, memory drive and response return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr         <= {addr_width{1'b0}};
      mem_data_in      <= {data_width{1'b0}};
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      we_r             <= 1'b0;
      win_r            <= 1'b0;
      p0_done          <= 1'b0;
      p1_done          <= 1'b0;
      p0_rdata         <= {data_width{1'b0}};
      p1_rdata         <= {data_width{1'b0}};
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            mem_addr         <= sel_addr_s;
            mem_data_in      <= sel_wdata_s;
            mem_write_enable <= sel_we_s;
            mem_read_enable  <= ~sel_we_s;
            we_r             <= sel_we_s;
            win_r            <= win_s;
          end
        end
        ISSUE: begin
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
        end
        RESP: begin
          // memory_v2 read data is valid in the cycle after the enable.
          if (win_r) begin
            p1_done <= 1'b1;
            if (!we_r) begin
              p1_rdata <= mem_data_out;
            end
          end else begin
            p0_done <= 1'b1;
            if (!we_r) begin
              p0_rdata <= mem_data_out;
            end
          end
        end
        default: begin
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_v1.sv
// Self-checking bench for mem_arbiter_v1: memory_v2 behavioural model plus a transaction-level
// reference that predicts grants, enables, done timing and read data from the arbitration rules.
module tb_mem_arbiter_v1;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p0_gnt, p0_done;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_gnt, p1_done;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_write_enable, mem_read_enable, busy;

  mem_arbiter_v1 #(.addr_width(AW), .data_width(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int a);
    if (a == 16) return 32'hDEADBEEF;
    return 32'hA500_0000 | DW'(a);
  endfunction

  // memory_v2 model: one-cycle read latency
  logic [DW-1:0] ram [0:1023];
  logic          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
      ram_init <= 1'b1;
    end else begin
      if (mem_write_enable) ram[mem_addr] <= mem_data_in;
      if (mem_read_enable) mem_data_out <= ram[mem_addr];
    end
  end

  // Reference model state
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [DW-1:0] shadow [0:1023];
  bit            pend;
  int            pend_port, pend_issue, pend_done;
  bit            pend_we;
  logic [DW-1:0] pend_rd;
  logic [DW-1:0] exp_rdata [2];
  logic [AW-1:0] exp_maddr;
  logic [DW-1:0] exp_mdin;
  int            last_win;
  bit            g0_seen, g1_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_maddr = '0;
    exp_mdin = '0;
    last_win = -1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_p0_gnt"}, p0_gnt, 0);
    check_eq({tag, "_p1_gnt"}, p1_gnt, 0);
    check_eq({tag, "_p0_done"}, p0_done, 0);
    check_eq({tag, "_p1_done"}, p1_done, 0);
    check_eq({tag, "_p0_rdata"}, p0_rdata, 0);
    check_eq({tag, "_p1_rdata"}, p1_rdata, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_data_in"}, mem_data_in, 0);
    check_eq({tag, "_mem_we"}, mem_write_enable, 0);
    check_eq({tag, "_mem_re"}, mem_read_enable, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // One cycle of prediction and comparison, sampled mid-cycle
  task automatic check_cycle();
    bit d0, d1, re, we, g0, g1;
    int w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    d0 = 0; d1 = 0; re = 0; we = 0; g0 = 0; g1 = 0;
    if (pend && cyc == pend_done) begin
      if (pend_port == 0) d0 = 1; else d1 = 1;
      if (!pend_we) exp_rdata[pend_port] = pend_rd;
      pend = 1'b0;
    end
    if (pend && cyc == pend_issue) begin
      re = !pend_we;
      we = pend_we;
    end
    check_eq("mem_addr", mem_addr, exp_maddr);
    check_eq("mem_data_in", mem_data_in, exp_mdin);
    if (!pend && (p0_req || p1_req)) begin
      if (p0_req && p1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = (last_win == 0) ? 1 : 0;
`else
        w = 1;
`endif
      end else begin
        w = p1_req ? 1 : 0;
      end
      if (w == 0) g0 = 1; else g1 = 1;
      last_win = w;
      pend = 1'b1;
      pend_port = w;
      pend_issue = cyc + 1;
      pend_done = cyc + 3;
      pend_we = (w == 1) ? p1_we : p0_we;
      a = (w == 1) ? p1_addr : p0_addr;
      wd = (w == 1) ? p1_wdata : p0_wdata;
      exp_maddr = a;
      exp_mdin = wd;
      if (pend_we) shadow[a] = wd;
      else pend_rd = shadow[a];
    end
    check_eq("p0_gnt", p0_gnt, g0);
    check_eq("p1_gnt", p1_gnt, g1);
    check_eq("mem_read_enable", mem_read_enable, re);
    check_eq("mem_write_enable", mem_write_enable, we);
    check_eq("p0_done", p0_done, d0);
    check_eq("p1_done", p1_done, d1);
    check_eq("p0_rdata", p0_rdata, exp_rdata[0]);
    check_eq("p1_rdata", p1_rdata, exp_rdata[1]);
    check_eq("busy", busy, pend);
    g0_seen = p0_gnt;
    g1_seen = p1_gnt;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (g0_seen) p0_req = 1'b0;
    if (g1_seen) p1_req = 1'b0;
  endtask

  task automatic set_req(input int port, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(3))
      0:       return 10'h010;
      1:       return 10'h3FF;
      default: return AW'($urandom_range(15));
    endcase
  endfunction

  task automatic new_req(input int port, input int pct);
    bit busy_port;
    busy_port = (port == 0) ? p0_req : p1_req;
    if (!busy_port && $urandom_range(99) < pct)
      set_req(port, 1'($urandom_range(1)), pick_addr(), $urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    model_reset();
    rst = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h010; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0;      p1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    p0_req = 1'b0;
    rst = 1'b1;

    // Single read of preloaded word
    set_req(0, 1'b0, 10'h010, '0);
    repeat (5) step();

    // Write then read at top address on port 1
    set_req(1, 1'b1, 10'h3FF, 32'h12345678);
    repeat (4) step();
    set_req(1, 1'b0, 10'h3FF, '0);
    repeat (4) step();
    check_eq("p1_read_3ff", p1_rdata, 32'h12345678);
    check_eq("p0_rdata_kept", p0_rdata, 32'hDEADBEEF);

    // Back-to-back: new p0 request in the cycle of its done
    set_req(0, 1'b0, 10'h005, '0);
    repeat (3) step();
    set_req(0, 1'b1, 10'h006, 32'h0BADF00D);
    repeat (4) step();

    // Contention: both ports keep requesting
    for (int i = 0; i < 24; i++) begin
      new_req(0, 100);
      new_req(1, 100);
      step();
    end
    repeat (8) step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      new_req(0, 40);
      new_req(1, 40);
      step();
    end
    repeat (8) step();

    // Reset during ISSUE
    set_req(0, 1'b0, 10'h010, '0);
    step();
    rst = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    repeat (3) step();
    rst = 1'b1;
    repeat (5) step();
    set_req(0, 1'b0, 10'h3FF, '0);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_v1.md
# mem_arbiter_v1

Two-port arbiter and sequencer that shares the single `memory_v2` access port between the core's instruction-fetch requester (port 0) and load/store requester (port 1). It accepts one request at a time through a req/gnt handshake, registers the command, and drives `memory_v2` for exactly one cycle. It then captures the one-cycle-latency read data and returns a `done` pulse with the data to the winning port. It sits between the core pipeline and `memory_v2`.

## Interface
Parameters:
- `addr_width`, default 10: width of all address buses; matches `memory_v2`.
- `data_width`, default 32: width of all data buses.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `p0_req`  in  1  port 0 request; held high until `p0_gnt`.
- `p0_we`  in  1  port 0 write (1) or read (0); sampled with `p0_req`.
- `p0_addr`  in  `addr_width`  port 0 address.
- `p0_wdata`  in  `data_width`  port 0 write data.
- `p0_gnt`  out  1  port 0 request accepted this cycle.
- `p0_done`  out  1  one-cycle pulse: port 0 access complete.
- `p0_rdata`  out  `data_width`  port 0 read data; valid while `p0_done` is high, held afterwards.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_gnt`, `p1_done`, `p1_rdata`: same as port 0, for port 1.
- `mem_addr`  out  `addr_width`  to `memory_v2` `mem_addr`.
- `mem_data_in`  out  `data_width`  to `memory_v2` `data_in`.
- `mem_write_enable`  out  1  to `memory_v2` `write_enable`.
- `mem_read_enable`  out  1  to `memory_v2` `read_enable`.
- `mem_data_out`  in  `data_width`  from `memory_v2` `data_out`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: if any `pX_req`, assert the winner's `pX_gnt` combinationally, capture addr/we/wdata/port-id, go to ISSUE. Otherwise stay.
  - ISSUE: drive `mem_read_enable` = !we and `mem_write_enable` = we for this cycle only; go to RESP.
  - RESP: if the access is a read, register `mem_data_out` into the winner's `rdata`. Set the winner's `done` register; go to IDLE.
- Only one `gnt` is ever high in a cycle. A `gnt` is only asserted in IDLE.
- Arbitration when both ports request in the same cycle is set by Configuration. A single requester always wins.
- `mem_addr` and `mem_data_in` are registered and hold the last captured values outside ISSUE. The enables are 0 outside ISSUE.
- `pX_rdata` updates only on reads by that port. Writes leave it unchanged.
- The loser's request stays pending. It is granted in the IDLE cycle after the current access completes, unless it is beaten again.
- Reset (asserted at any time, including mid-access): immediately return to IDLE. All outputs go to 0: `gnt`, `done`, `rdata`, `mem_*`, `busy`, and the round-robin pointer. The in-flight access is dropped and no `done` is issued.

## Timing
- Cycle 0: IDLE, req and gnt high.
- Cycle 1: ISSUE, memory enable high.
- Cycle 2: RESP, read data sampled from `memory_v2`.
- Cycle 3: IDLE, `done` and `rdata` valid.
- Latency from grant to `done` is 3 cycles for both reads and writes.
- A new grant can occur in the same cycle as the previous `done` (cycle 3). Peak throughput is one access per 3 cycles.
- `done` is a registered single-cycle pulse.
- A requester may drop `req` only after seeing `gnt`. It may issue a new `req` in the cycle of its own `done`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, grant the port not granted most recently. A 1-bit last-winner pointer updates on every grant and resets so that port 0 wins first.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, port 1 (load/store) always wins simultaneous requests. No pointer register.

## Test plan
- Single read: preload RAM[0x010] = 0xDEADBEEF, p0 read 0x010 -> `p0_gnt` at cycle 0, `mem_read_enable` high only at cycle 1, `p0_done` with `p0_rdata` = 0xDEADBEEF at cycle 3.
- Write then read: p1 write 0x3FF with 0x12345678, then p1 read 0x3FF -> `mem_write_enable` 1 cycle with `mem_addr` = 0x3FF, read returns 0x12345678, `p0_rdata` unchanged.
- Contention: p0 and p1 both hold req continuously.
  - With the macro: grants alternate p0, p1, p0, p1.
  - Without the macro: p1 is granted every time while held, and p0 is granted only after p1 drops req.
- Back-to-back: p0 issues a new req in the cycle of its `done` -> granted that same cycle, `busy` never drops.
- Reset mid-access: assert `rst` = 0 during ISSUE -> all outputs 0 immediately, no `done` after release, next request completes normally in 3 cycles.
